// File: rtl/avalon_st_packet_compare.sv
// Lockstep comparator for two Avalon-ST packet streams: joins A and B beat by beat,
// reports per-packet match / first differing beat and keeps saturating statistics.
module avalon_st_packet_compare #(
    parameter int DATA_WIDTH  = 64,
    parameter int EMPTY_WIDTH = 3,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_WIDTH-1:0]  a_data,
    input  logic                   a_valid,
    input  logic                   a_sop,
    input  logic                   a_eop,
    input  logic [EMPTY_WIDTH-1:0] a_empty,
    output logic                   a_ready,
    input  logic [DATA_WIDTH-1:0]  b_data,
    input  logic                   b_valid,
    input  logic                   b_sop,
    input  logic                   b_eop,
    input  logic [EMPTY_WIDTH-1:0] b_empty,
    output logic                   b_ready,
    input  logic                   enable,
    input  logic                   clear,
    output logic                   result_valid,
    output logic                   result_match,
    output logic [CNT_WIDTH-1:0]   mismatch_beat,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic [CNT_WIDTH-1:0]   err_count,
    output logic                   err_sticky
);

    localparam int NBYTES = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PKT     = 2'd1;
    localparam logic [1:0] DRAIN_A = 2'd2;
    localparam logic [1:0] DRAIN_B = 2'd3;

    logic [1:0]            state, state_next;
    logic [CNT_WIDTH-1:0]  beat_idx, first_bad, cur_idx, idx_next;
    logic                  pkt_bad, prior_bad, beat_bad, bad_next;
    logic                  a_fire, b_fire, joined, both_eop, beat_diff;
    logic                  advance, pkt_end, idle_drop;
    logic [DATA_WIDTH-1:0] data_mask;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Big-endian byte order: the empty bytes are the least-significant ones.
    function automatic logic [DATA_WIDTH-1:0] eop_mask(input logic [EMPTY_WIDTH-1:0] empty);
        logic [DATA_WIDTH-1:0] m;
        m = '1;
        for (int i = 0; i < NBYTES; i++)
            if (i < int'(empty)) m[i*8 +: 8] = 8'h00;
        return m;
    endfunction

    // Ready is derived from the partner's valid only, never from a ready.
    assign a_ready = reset_n & enable &
                     ((((state == IDLE) | (state == PKT)) & b_valid) | (state == DRAIN_A));
    assign b_ready = reset_n & enable &
                     ((((state == IDLE) | (state == PKT)) & a_valid) | (state == DRAIN_B));
    assign a_fire  = a_valid & a_ready;
    assign b_fire  = b_valid & b_ready;

    always_comb begin
        joined    = a_fire & b_fire;
        both_eop  = a_eop & b_eop;
        data_mask = both_eop ? eop_mask(a_empty) : '1;
        beat_diff = (((a_data ^ b_data) & data_mask) != '0) || (a_sop != b_sop) ||
                    (a_eop != b_eop) || (both_eop && (a_empty != b_empty));
        cur_idx    = (state == IDLE) ? '0 : beat_idx;
        prior_bad  = (state != IDLE) & pkt_bad;
        beat_bad   = 1'b0;
        advance    = 1'b0;
        pkt_end    = 1'b0;
        state_next = state;
        case (state)
            IDLE, PKT: begin
                beat_bad = beat_diff | ((state == PKT) & (a_sop | b_sop));
                advance  = joined & ((state == PKT) | (a_sop & b_sop));
                pkt_end  = advance & both_eop;
                if (advance)
                    state_next = both_eop ? IDLE : a_eop ? DRAIN_B : b_eop ? DRAIN_A : PKT;
            end
            DRAIN_A: begin
                beat_bad = a_sop;
                advance  = a_fire;
                pkt_end  = a_fire & a_eop;
                if (pkt_end) state_next = IDLE;
            end
            default: begin
                beat_bad = b_sop;
                advance  = b_fire;
                pkt_end  = b_fire & b_eop;
                if (pkt_end) state_next = IDLE;
            end
        endcase
        bad_next  = prior_bad | beat_bad;
        idx_next  = (!prior_bad && beat_bad) ? cur_idx : first_bad;
        idle_drop = (state == IDLE) & joined & ~(a_sop & b_sop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            beat_idx      <= '0;
            first_bad     <= '1;
            pkt_bad       <= 1'b0;
            result_valid  <= 1'b0;
            result_match  <= 1'b0;
            mismatch_beat <= '1;
            pkt_count     <= '0;
            err_count     <= '0;
            err_sticky    <= 1'b0;
        end else begin
            state        <= state_next;
            result_valid <= pkt_end;
            if (advance) begin
                beat_idx  <= cur_idx + 1'b1;
                pkt_bad   <= bad_next;
                first_bad <= idx_next;
            end
            if (pkt_end) begin
                result_match  <= ~bad_next;
                mismatch_beat <= bad_next ? idx_next : '1;
            end
            // Clear outranks a coincident packet end for the statistics only.
            if (clear) begin
                pkt_count  <= '0;
                err_count  <= '0;
                err_sticky <= 1'b0;
            end else begin
                if (pkt_end) pkt_count <= sat_inc(pkt_count);
                if (pkt_end && bad_next) err_count <= sat_inc(err_count);
                if (idle_drop || (pkt_end && bad_next)) err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_st_packet_compare.sv
// Directed and randomized bench for avalon_st_packet_compare, checked against a
// byte-level packet model (narrow counters so saturation is reachable).
module tb_avalon_st_packet_compare;

    localparam int DW = 64;
    localparam int EW = 3;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk, reset_n;
    logic [DW-1:0] a_data, b_data;
    logic          a_valid, a_sop, a_eop, a_ready;
    logic          b_valid, b_sop, b_eop, b_ready;
    logic [EW-1:0] a_empty, b_empty;
    logic          enable, clear;
    logic          result_valid, result_match, err_sticky;
    logic [CW-1:0] mismatch_beat, pkt_count, err_count;

    avalon_st_packet_compare #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_data(a_data), .a_valid(a_valid), .a_sop(a_sop), .a_eop(a_eop),
        .a_empty(a_empty), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_sop(b_sop), .b_eop(b_eop),
        .b_empty(b_empty), .b_ready(b_ready),
        .enable(enable), .clear(clear),
        .result_valid(result_valid), .result_match(result_match),
        .mismatch_beat(mismatch_beat), .pkt_count(pkt_count),
        .err_count(err_count), .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          m;
        logic [CW-1:0] mb, pc, ec;
        logic          st;
    } rec_t;
    rec_t res_q[$];

    always @(negedge clk)
        if (result_valid === 1'b1)
            res_q.push_back('{m: result_match, mb: mismatch_beat, pc: pkt_count,
                              ec: err_count, st: err_sticky});

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] pa[$], pb[$];
    int la, lb;
    int exp_pkt = 0, exp_err = 0;
    bit exp_st = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic gen_a(input int len);
        pa.delete();
        la = len;
        for (int i = 0; i < ((len + 7) / 8) * 8; i++) pa.push_back(8'($urandom));
    endtask

    task automatic copy_b(input int len);
        pb.delete();
        lb = len;
        for (int i = 0; i < ((len + 7) / 8) * 8; i++)
            pb.push_back((i < pa.size()) ? pa[i] : 8'($urandom));
    endtask

    function automatic logic [63:0] beat_of(input bit side_b, input int k);
        logic [63:0] d;
        for (int j = 0; j < 8; j++)
            d[63-8*j -: 8] = side_b ? pb[8*k+j] : pa[8*k+j];
        return d;
    endfunction

    // Packet-level reference: index of the first differing beat, -1 when equal.
    function automatic int first_diff(input int msop);
        int na, nb, nvalid;
        bit lasta, lastb;
        na = (la + 7) / 8;
        nb = (lb + 7) / 8;
        for (int i = 0; i < na && i < nb; i++) begin
            lasta = (i == na - 1);
            lastb = (i == nb - 1);
            if (i == msop) return i;
            if (lasta != lastb) return i;
            if (lasta && la != lb) return i;
            nvalid = lasta ? la - 8 * i : 8;
            for (int j = 0; j < nvalid; j++)
                if (pa[8*i+j] != pb[8*i+j]) return i;
        end
        return -1;
    endfunction

    task automatic run_pkt(input int b_hold, input bit rnd, input int msop, input bit clr_end);
        int na, nb, ia, ib, cyc, fd;
        bit ra, rb;
        rec_t r;
        na = (la + 7) / 8;
        nb = (lb + 7) / 8;
        ia = 0; ib = 0; cyc = 0;
        while ((ia < na || ib < nb) && cyc < 400) begin
            @(negedge clk);
            a_valid = (ia < na) && (!rnd || $urandom_range(0, 3) != 0);
            a_data  = beat_of(1'b0, (ia < na) ? ia : 0);
            a_sop   = (ia == 0) || (ia == msop);
            a_eop   = (ia == na - 1);
            a_empty = (ia == na - 1) ? EW'(na * 8 - la) : EW'($urandom_range(0, 7));
            b_valid = (ib < nb) && (cyc >= b_hold) && (!rnd || $urandom_range(0, 3) != 0);
            b_data  = beat_of(1'b1, (ib < nb) ? ib : 0);
            b_sop   = (ib == 0) || (ib == msop);
            b_eop   = (ib == nb - 1);
            b_empty = (ib == nb - 1) ? EW'(nb * 8 - lb) : EW'($urandom_range(0, 7));
            enable  = !rnd || $urandom_range(0, 4) != 0;
            clear   = clr_end && a_valid && b_valid && enable && ia == na - 1 && ib == nb - 1;
            #1;
            ra = a_ready;
            rb = b_ready;
            if (!enable) begin
                chk("a_ready_disabled", 64'(ra), 64'(0));
                chk("b_ready_disabled", 64'(rb), 64'(0));
            end else if (ia < na && ib < nb) begin
                chk("lockstep_a_ready", 64'(ra), 64'(b_valid));
                chk("lockstep_b_ready", 64'(rb), 64'(a_valid));
            end else if (ib < nb) begin
                chk("drain_b_a_ready", 64'(ra), 64'(0));
                chk("drain_b_b_ready", 64'(rb), 64'(1));
            end else begin
                chk("drain_a_a_ready", 64'(ra), 64'(1));
                chk("drain_a_b_ready", 64'(rb), 64'(0));
            end
            @(posedge clk);
            if (a_valid && ra) ia++;
            if (b_valid && rb) ib++;
            cyc++;
        end
        chk("packet_consumed", 64'(cyc < 400), 64'(1));
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; clear = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clk);
        fd = first_diff(msop);
        if (clr_end) begin
            exp_pkt = 0; exp_err = 0; exp_st = 0;
        end else begin
            exp_pkt = sat(exp_pkt + 1);
            if (fd >= 0) begin
                exp_err = sat(exp_err + 1);
                exp_st  = 1'b1;
            end
        end
        chk("result_count", 64'(res_q.size()), 64'(1));
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk("result_match", 64'(r.m), 64'(fd < 0));
            chk("mismatch_beat", 64'(r.mb), (fd < 0) ? 64'(CMAX) : 64'(fd));
            chk("pkt_count", 64'(r.pc), 64'(exp_pkt));
            chk("err_count", 64'(r.ec), 64'(exp_err));
            chk("err_sticky", 64'(r.st), 64'(exp_st));
        end
        res_q.delete();
    endtask

    task automatic drive_raw(input logic [63:0] da, input logic [63:0] db,
                             input bit sa, input bit sb, input bit ea, input bit eb);
        @(negedge clk);
        a_data = da; b_data = db; a_sop = sa; b_sop = sb; a_eop = ea; b_eop = eb;
        a_empty = '0; b_empty = '0;
        a_valid = 1'b1; b_valid = 1'b1; enable = 1'b1; clear = 1'b0;
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        int mode;
        reset_n = 1'b0; enable = 1'b1; clear = 1'b0;
        a_data = '0; a_valid = 1'b1; a_sop = 1'b0; a_eop = 1'b0; a_empty = '0;
        b_data = '0; b_valid = 1'b1; b_sop = 1'b0; b_eop = 1'b0; b_empty = '0;
        #16;
        chk("rst_a_ready", 64'(a_ready), 64'(0));
        chk("rst_b_ready", 64'(b_ready), 64'(0));
        chk("rst_result_valid", 64'(result_valid), 64'(0));
        chk("rst_result_match", 64'(result_match), 64'(0));
        chk("rst_mismatch_beat", 64'(mismatch_beat), 64'(CMAX));
        chk("rst_pkt_count", 64'(pkt_count), 64'(0));
        chk("rst_err_count", 64'(err_count), 64'(0));
        chk("rst_err_sticky", 64'(err_sticky), 64'(0));
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; reset_n = 1'b1;

        // 20-byte identical packets
        gen_a(20); copy_b(20);
        run_pkt(0, 1'b0, -1, 1'b0);
        // byte 17 differs, then a difference hidden in an empty byte
        gen_a(20); copy_b(20); pb[17] ^= 8'h5A;
        run_pkt(0, 1'b0, -1, 1'b0);
        gen_a(20); copy_b(20); pb[21] ^= 8'h33;
        run_pkt(0, 1'b0, -1, 1'b0);
        // A 3 beats, B 5 beats; then the symmetric drain of A
        gen_a(24); copy_b(40);
        run_pkt(0, 1'b1, -1, 1'b0);
        gen_a(32); copy_b(8);
        run_pkt(0, 1'b0, -1, 1'b0);
        // B held off for 10 cycles
        gen_a(16); copy_b(16);
        run_pkt(10, 1'b0, -1, 1'b0);
        // sop on both streams mid-packet
        gen_a(32); copy_b(32);
        run_pkt(0, 1'b0, 2, 1'b0);
        // drive the counters into saturation
        for (int k = 0; k < 18; k++) begin
            gen_a(16); copy_b(16); pb[$urandom_range(0, 15)] ^= 8'h01;
            run_pkt(0, 1'b1, -1, 1'b0);
        end
        chk("err_count_saturated", 64'(err_count), 64'(CMAX));
        // clear coincident with the packet end
        gen_a(16); copy_b(16); pb[3] ^= 8'h80;
        run_pkt(0, 1'b0, -1, 1'b1);
        chk("clear_pkt_count", 64'(pkt_count), 64'(0));

        for (int k = 0; k < 30; k++) begin
            gen_a($urandom_range(1, 40));
            mode = $urandom_range(0, 3);
            case (mode)
                0: copy_b(la);
                1: begin copy_b(la); pb[$urandom_range(0, pb.size() - 1)] ^= 8'h10; end
                2: copy_b($urandom_range(1, 40));
                default: copy_b((la == 1) ? 2 : la - 1);
            endcase
            run_pkt(0, 1'b1, -1, 1'b0);
        end

        // non-sop beat in IDLE is dropped and flagged
        exp_st = 1'b1;
        drive_raw(64'h1, 64'h1, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("drop_no_result", 64'(res_q.size()), 64'(0));
        chk("drop_sticky", 64'(err_sticky), 64'(1));
        chk("drop_pkt_count", 64'(pkt_count), 64'(exp_pkt));

        // reset in the middle of a 3-beat packet
        gen_a(24); copy_b(24);
        drive_raw(beat_of(1'b0, 0), beat_of(1'b1, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        drive_raw(beat_of(1'b0, 1), beat_of(1'b1, 1), 1'b0, 1'b0, 1'b0, 1'b0);
        a_valid = 1'b1; b_valid = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_a_ready", 64'(a_ready), 64'(0));
        chk("mid_rst_b_ready", 64'(b_ready), 64'(0));
        chk("mid_rst_result_valid", 64'(result_valid), 64'(0));
        chk("mid_rst_result_match", 64'(result_match), 64'(0));
        chk("mid_rst_mismatch_beat", 64'(mismatch_beat), 64'(CMAX));
        chk("mid_rst_pkt_count", 64'(pkt_count), 64'(0));
        chk("mid_rst_err_count", 64'(err_count), 64'(0));
        chk("mid_rst_err_sticky", 64'(err_sticky), 64'(0));
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_pkt = 0; exp_err = 0; exp_st = 1'b1;
        drive_raw(beat_of(1'b0, 2), beat_of(1'b1, 2), 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("post_rst_no_result", 64'(res_q.size()), 64'(0));
        chk("post_rst_sticky", 64'(err_sticky), 64'(1));
        res_q.delete();
        gen_a(20); copy_b(20);
        run_pkt(0, 1'b0, -1, 1'b0);
        chk("post_rst_pkt_count", 64'(pkt_count), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
